// File: rtl/i_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package i_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO with occupancy count, flush, and combinational head.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so push at full is legal then.
    do_push = push && ((count_q != DEPTH_CNT) || do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch: issues sequential word requests, tracks in-flight responses,
// queues returned words with their PCs, and discards stale responses after a redirect.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QDEPTH_SUM = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   q_count, pcf_count;
  logic [XLEN-1:0] pcf_head;
  fetch_entry_t    q_head, q_push_data;
  logic            req_fire, resp_take, resp_keep, out_fire;
  logic            q_push, pcf_pop;

  always_comb begin
    imem_req_valid = !rst && !redirect_valid &&
                     (({1'b0, q_count} + {1'b0, inflight_q}) < QDEPTH_SUM);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    resp_take = imem_resp_valid && (inflight_q != '0);
    resp_keep = resp_take && (drop_cnt_q == '0) && (pcf_count != '0);
    // A response landing in a redirect cycle is retired but never queued.
    q_push    = resp_keep && !redirect_valid;
    pcf_pop   = q_push;

    out_valid = (q_count != '0);
    out_instr = q_head.instr;
    out_pc    = q_head.pc;
    out_fire  = out_valid && out_ready;

    q_push_data = '{pc: pcf_head, instr: imem_resp_data};

    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_take);

    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = inflight_d;
    end else if (resp_take && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= align_pc(RESET_PC);
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (QDEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (pcf_pop),
    .head_data (pcf_head),
    .count     (pcf_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (out_fire),
    .head_data (q_head),
    .count     (q_count)
  );

  resp_needs_request: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight_q != '0));

  inflight_accounting: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, inflight_q} == ({1'b0, drop_cnt_q} + {1'b0, pcf_count})));

endmodule

// File: tb/tb_i_fetch.sv
// Directed, table-driven bench for i_fetch (QDEPTH = 4, default RESET_PC).
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i_fetch #(
    .QDEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [63:0] rpc;
    logic        ordy;
    logic        e_rqv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] rdata, input logic redir,
                              input logic [63:0] rpc, input logic ordy,
                              input logic e_rqv, input logic [63:0] e_addr,
                              input logic e_ov, input logic [31:0] e_instr,
                              input logic [63:0] e_pc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir;
    v.rpc = rpc; v.ordy = ordy; v.e_rqv = e_rqv; v.e_addr = e_addr;
    v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // rst rdy rv rdata redir rpc ordy | rqv addr ov instr pc
    vecs.push_back(mk(1,1,0,32'h0,0,64'h0,1, 0,64'h0,0,32'h0,64'h0));
    vecs.push_back(mk(1,1,0,32'h0,0,64'h0,1, 0,64'h0,0,32'h0,64'h0));
    // streaming with 1-cycle response latency
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h0,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,1,32'hA000_0000,0,64'h0,1, 1,64'h4,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,1,32'hA000_0004,0,64'h0,1, 1,64'h8,1,32'hA000_0000,64'h0));
    vecs.push_back(mk(0,1,1,32'hA000_0008,0,64'h0,1, 1,64'hC,1,32'hA000_0004,64'h4));
    vecs.push_back(mk(0,1,1,32'hA000_000C,0,64'h0,1, 1,64'h10,1,32'hA000_0008,64'h8));
    // decoder stalls: queue fills to 4, requests stop, head held
    vecs.push_back(mk(0,1,1,32'hA000_0010,0,64'h0,0, 1,64'h14,1,32'hA000_000C,64'hC));
    vecs.push_back(mk(0,1,1,32'hA000_0014,0,64'h0,0, 1,64'h18,1,32'hA000_000C,64'hC));
    vecs.push_back(mk(0,1,1,32'hA000_0018,0,64'h0,0, 0,64'h1C,1,32'hA000_000C,64'hC));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,0,32'h0,0,64'h0,0, 0,64'h1C,1,32'hA000_000C,64'hC));
    // drain in order; simultaneous push/pop
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 0,64'h1C,1,32'hA000_000C,64'hC));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h1C,1,32'hA000_0010,64'h10));
    vecs.push_back(mk(0,1,1,32'hA000_001C,0,64'h0,1, 1,64'h20,1,32'hA000_0014,64'h14));
    vecs.push_back(mk(0,1,1,32'hA000_0020,0,64'h0,1, 1,64'h24,1,32'hA000_0018,64'h18));
    // memory not ready: request held stable
    vecs.push_back(mk(0,0,1,32'hA000_0024,0,64'h0,1, 1,64'h28,1,32'hA000_001C,64'h1C));
    vecs.push_back(mk(0,0,0,32'h0,0,64'h0,0, 1,64'h28,1,32'hA000_0020,64'h20));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h28,1,32'hA000_0020,64'h20));
    // redirect to unaligned 0x103 with a response and a consume in the same cycle
    vecs.push_back(mk(0,1,1,32'hA000_0028,1,64'h103,1, 0,64'h2C,1,32'hA000_0024,64'h24));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h100,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,1,32'hB000_0100,0,64'h0,1, 1,64'h104,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,0,32'h0,0,64'h0,1, 1,64'h104,1,32'hB000_0100,64'h100));
    // two in flight at 0x10/0x14, redirect to 0x200 drops both
    vecs.push_back(mk(0,1,0,32'h0,1,64'h10,1, 0,64'h104,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h10,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h14,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,1,64'h200,1, 0,64'h18,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,1,32'hDEAD_0010,0,64'h0,1, 1,64'h200,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,1,32'hDEAD_0014,0,64'h0,1, 1,64'h204,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,1,32'hC000_0200,0,64'h0,1, 1,64'h204,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,0,32'h0,0,64'h0,0, 1,64'h204,1,32'hC000_0200,64'h200));
    vecs.push_back(mk(0,0,0,32'h0,0,64'h0,1, 1,64'h204,1,32'hC000_0200,64'h200));
    // PC wrap at top of address space
    vecs.push_back(mk(0,0,0,32'h0,1,64'hFFFF_FFFF_FFFF_FFFE,1, 0,64'h204,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'hFFFF_FFFF_FFFF_FFFC,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,1,32'hE000_FFFC,0,64'h0,1, 1,64'h0,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,0,32'h0,0,64'h0,1, 1,64'h0,1,32'hE000_FFFC,64'hFFFF_FFFF_FFFF_FFFC));
    // back-to-back redirects: last wins
    vecs.push_back(mk(0,1,0,32'h0,1,64'h300,1, 0,64'h0,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,1,64'h400,1, 0,64'h300,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h400,0,32'h0,64'h0));
    vecs.push_back(mk(0,0,0,32'h0,0,64'h0,1, 1,64'h404,0,32'h0,64'h0));
    vecs.push_back(mk(0,1,0,32'h0,0,64'h0,1, 1,64'h404,0,32'h0,64'h0));

    foreach (vecs[i]) begin
      rst             = vecs[i].rst;
      imem_req_ready  = vecs[i].rdy;
      imem_resp_valid = vecs[i].rv;
      imem_resp_data  = vecs[i].rdata;
      redirect_valid  = vecs[i].redir;
      redirect_pc     = vecs[i].rpc;
      out_ready       = vecs[i].ordy;
      @(negedge clk);
      check("req_valid", i, 64'(imem_req_valid), 64'(vecs[i].e_rqv));
      check("req_addr",  i, imem_req_addr, vecs[i].e_addr);
      check("out_valid", i, 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov || vecs[i].rst) begin
        check("out_instr", i, 64'(out_instr), 64'(vecs[i].e_instr));
        check("out_pc",    i, out_pc, vecs[i].e_pc);
      end
      @(posedge clk); #1;
    end

    // Mid-operation reset with two requests (0x400, 0x404) in flight.
    redirect_valid = 1'b0; imem_resp_valid = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_req_valid", 0, 64'(imem_req_valid), 64'h0);
    check("rst_req_addr",  0, imem_req_addr, 64'h0);
    check("rst_out_valid", 0, 64'(out_valid), 64'h0);
    check("rst_out_instr", 0, 64'(out_instr), 64'h0);
    check("rst_out_pc",    0, out_pc, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0400;
    @(posedge clk); #1;
    imem_resp_data = 32'hBAD0_0404;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check("restart_req_valid", 0, 64'(imem_req_valid), 64'h1);
    check("restart_req_addr",  0, imem_req_addr, 64'h0);
    check("restart_out_valid", 0, 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hF000_0000;
    @(negedge clk);
    check("restart_latency", 0, 64'(out_valid), 64'h0);
    check("restart_next_addr", 0, imem_req_addr, 64'h4);
    @(posedge clk); #1;
    imem_resp_valid = 1'b0; out_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("restart_out_seen", 0, 64'(found), 64'h1);
    check("restart_out_instr", 0, 64'(out_instr), 64'hF000_0000);
    check("restart_out_pc", 0, out_pc, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_fetch.md
I_FETCH -- requirements
Module: i_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the instruction queue depth in entries; legal values are powers of two, 2 to 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request present.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  64  fetch byte address, bits [1:0] = 00.
REQ-008 imem_resp_valid  input  1  one 32-bit response word present; responses return in order.
REQ-009 imem_resp_data  input  32  response instruction word.
REQ-010 redirect_valid  input  1  taken branch, jump or trap; restart fetch.
REQ-011 redirect_pc  input  64  new fetch address; bits [1:0] are ignored and treated as 00.
REQ-012 out_valid  output  1  queue head holds an instruction for the decoder.
REQ-013 out_ready  input  1  decoder consumes the head this cycle.
REQ-014 out_instr  output  32  head instruction word, wired directly to the decoder instruction input.
REQ-015 out_pc  output  64  address of out_instr.

Function
REQ-016 A request transfer SHALL occur when imem_req_valid and imem_req_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 imem_req_valid SHALL be 1 iff (queue count + inflight) < QDEPTH and redirect_valid = 0.
- inflight = requests accepted whose responses have not returned.
- Full queue: no new requests are issued.
REQ-018 imem_req_valid and imem_req_addr SHALL stay stable while stalled waiting for ready, unless a redirect occurs.
REQ-019 On each request transfer, fetch_pc SHALL advance by 4, wrapping modulo 2^64.
REQ-020 The PC of each request SHALL be pushed to an internal PC FIFO in the same cycle; each kept response SHALL pop that FIFO, and the word and its PC are written to the queue together.
REQ-021 A response SHALL reach out_valid no earlier than the cycle after imem_resp_valid (registered queue, latency 1).
REQ-022 Simultaneous push and pop of the queue SHALL be legal at any count, including full.
REQ-023 out_instr and out_pc SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-024 On redirect_valid = 1, the following SHALL happen in that cycle:
- flush the queue; out_valid = 0 next cycle;
- set fetch_pc = redirect_pc;
- set drop_cnt = inflight, plus 1 if a response is not arriving this cycle but a request was in flight. Precisely: drop_cnt = inflight after this cycle's response is counted.
REQ-025 While drop_cnt > 0, each response SHALL be discarded and decrement drop_cnt; a discarded response is not written to the queue.
REQ-026 Redirect with out_ready = 1 in the same cycle: the head consumed in that cycle SHALL count as transferred; everything else is flushed.
REQ-027 Back-to-back redirects SHALL be legal; the last redirect wins and drop_cnt is recomputed each time.
REQ-028 A response arriving with inflight = 0 SHALL never happen; the block ignores it and fires an assertion.

Reset
REQ-029 While rst = 1, the following SHALL hold:
- fetch_pc = RESET_PC;
- queue, PC FIFO, inflight and drop_cnt = 0;
- imem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0.
REQ-030 The first request SHALL be issued in the first cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL drop all state; responses that arrive later SHALL be ignored per REQ-028 without corrupting state.

Structure
REQ-032 A shared package SHALL hold RESET_PC default, ILEN = 32, XLEN = 64 and the NOP encoding 32'h0000_0013.
REQ-033 One sub-module fetch_fifo (parameterised width/depth, count output, push/pop/flush) SHALL be instantiated twice: the PC FIFO and the instruction+PC queue.
REQ-034 The counters SHALL be $clog2(QDEPTH)+1 bits wide.

Verification
REQ-035 Reset release, memory ready always, 1-cycle response latency, out_ready = 1 -> addresses 0, 4, 8, ... issued; out_pc matches, one instruction per cycle after fill.
REQ-036 out_ready = 0 for 10 cycles -> exactly QDEPTH requests issued, then imem_req_valid = 0; out_instr held stable; resuming out_ready drains in order.
REQ-037 Two requests in flight (PC 0x10, 0x14), redirect to 0x200 -> both responses dropped; first out_pc = 0x200.
REQ-038 redirect_pc = 0x103 -> imem_req_addr = 0x100.
REQ-039 fetch_pc = 64'hFFFF_FFFF_FFFF_FFFC, request accepted -> next address = 0.
REQ-040 rst asserted with 2 requests in flight -> outputs zero immediately; late responses ignored; fetch restarts at RESET_PC.
